stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MINUTES_MAX, default 59, the last minute value before wrap (legal range 1..99).
REQ-002 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port tick, input, 1 bit: one-cycle pulse from the 1 s tick divider.
REQ-005 SHALL have port start_stop, input, 1 bit: one-cycle command pulse, already debounced.
REQ-006 SHALL have port lap, input, 1 bit: one-cycle command pulse, already debounced.
REQ-007 SHALL have port clear, input, 1 bit: one-cycle command pulse, already debounced.
REQ-008 SHALL have port div_rst, output, 1 bit: registered reset to the tick divider.
REQ-009 SHALL have port running, output, 1 bit: high in RUNNING or LAP.
REQ-010 SHALL have port lap_active, output, 1 bit: high in LAP.
REQ-011 SHALL have port state, output, 2 bits, with encoding IDLE=0, RUNNING=1, PAUSED=2, LAP=3.
REQ-012 SHALL have ports disp_sec_ones, disp_sec_tens, disp_min_ones and disp_min_tens, each output, 4 bits, BCD display digits.
REQ-013 SHALL have port rollover, output, 1 bit: one-cycle pulse on wrap to 00:00.

Function
REQ-014 SHALL implement a four-state FSM (IDLE, RUNNING, PAUSED, LAP), with all outputs registered.
REQ-015 SHALL apply command priority clear > start_stop > lap when pulses coincide; lower-priority pulses in the same cycle are dropped.
REQ-016 SHALL make these transitions, each taking effect the cycle after the pulse:
- clear (any state) -> IDLE
- IDLE + start_stop -> RUNNING
- RUNNING + start_stop -> PAUSED
- PAUSED + start_stop -> RUNNING
- LAP + start_stop -> PAUSED
- RUNNING + lap -> LAP
- LAP + lap -> RUNNING
REQ-017 SHALL ignore lap in IDLE and PAUSED.
REQ-018 SHALL drive div_rst = 1 in IDLE and PAUSED and 0 in RUNNING and LAP, so that the first tick after a start or resume arrives one full divider period later.
REQ-019 SHALL increment the live count on tick only when the current state is RUNNING or LAP and no clear is present; the updated value is visible the next cycle (latency 1).
REQ-020 SHALL keep the live count as four BCD digits, each 0-9, and SHALL carry seconds at 9/59 and minutes ones at 9.
REQ-021 SHALL take the step from MINUTES_MAX:59 on tick to 00:00, with rollover = 1 for exactly that next cycle; the state is unchanged.
REQ-022 SHALL capture the live count into a lap register on RUNNING + lap, using the pre-increment value if a tick coincides; the live count still increments.
REQ-023 SHALL output the lap register on disp_* in LAP and the live count in all other states.
REQ-024 SHALL zero the live count and lap register on clear; a tick coincident with clear is discarded.
REQ-025 SHALL preserve the live count in PAUSED and restore it to display on leaving LAP.
REQ-026 SHALL ignore ticks in IDLE and PAUSED, including ticks arriving while div_rst is asserted.

Reset
REQ-027 SHALL, on rst = 1 at a clk edge, set: state = IDLE, div_rst = 1, running = 0, lap_active = 0, rollover = 0, all digits = 0, lap register = 0.
REQ-028 SHALL give rst precedence over all inputs, including mid-run and mid-lap.
REQ-029 SHALL make the first command accepted the one on the cycle after rst deasserts.

Verification
REQ-030 SHALL cover start/count: start_stop in IDLE, then 75 ticks -> next cycle state = 1, div_rst = 0; display reads 01:15.
REQ-031 SHALL cover pause/resume: at 00:10 pulse start_stop, 5 ticks, start_stop, 3 ticks -> display 00:13; div_rst = 1 only while PAUSED.
REQ-032 SHALL cover lap: at 00:20 pulse lap, 10 ticks -> display holds 00:20, lap_active = 1; then lap -> display 00:30.
REQ-033 SHALL cover wrap: MINUTES_MAX = 1, run to 01:59, one tick -> display 00:00, rollover high for exactly one cycle.
REQ-034 SHALL cover simultaneous events: clear + start_stop + tick in the same cycle while RUNNING at 00:42 -> state IDLE, display 00:00; lap + tick at 00:05 -> lap display 00:05, live count 00:06.
REQ-035 SHALL cover reset mid-operation: rst while in LAP at 03:07 -> all outputs at reset values next cycle; a start_stop one cycle later is accepted.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUNNING/PAUSED/LAP FSM with a four-digit BCD mm:ss
// live count, a lap capture register and registered display/status outputs.
module stopwatch_ctrl #(
  parameter int MINUTES_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       div_rst,
  output logic       running,
  output logic       lap_active,
  output logic [1:0] state,
  output logic [3:0] disp_sec_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_min_tens,
  output logic       rollover
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_t;

  localparam logic [3:0] MAX_TENS = 4'(MINUTES_MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(MINUTES_MAX % 10);

  // Digit packing: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
  state_t      state_reg, state_next;
  logic [15:0] live_reg, live_next;
  logic [15:0] lap_reg, lap_next;
  logic [15:0] live_inc;
  logic [15:0] disp_reg;
  logic        div_rst_reg, running_reg, lap_active_reg, rollover_reg;
  logic        at_max, counting, wrap;

  assign at_max   = (live_reg == {MAX_TENS, MAX_ONES, 4'd5, 4'd9});
  assign counting = (state_reg == RUNNING) || (state_reg == LAP);

  always_comb begin
    live_inc = live_reg;
    if (at_max) begin
      live_inc = 16'h0000;
    end else if (live_reg[3:0] != 4'd9) begin
      live_inc[3:0] = live_reg[3:0] + 4'd1;
    end else begin
      live_inc[3:0] = 4'd0;
      if (live_reg[7:4] != 4'd5) begin
        live_inc[7:4] = live_reg[7:4] + 4'd1;
      end else begin
        live_inc[7:4] = 4'd0;
        if (live_reg[11:8] != 4'd9) begin
          live_inc[11:8] = live_reg[11:8] + 4'd1;
        end else begin
          live_inc[11:8]  = 4'd0;
          live_inc[15:12] = live_reg[15:12] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    live_next  = live_reg;
    lap_next   = lap_reg;
    wrap       = 1'b0;
    if (clear) begin
      state_next = IDLE;
      live_next  = 16'h0000;
      lap_next   = 16'h0000;
    end else begin
      case (state_reg)
        IDLE:    if (start_stop) state_next = RUNNING;
        RUNNING: begin
          if (start_stop) begin
            state_next = PAUSED;
          end else if (lap) begin
            state_next = LAP;
            lap_next   = live_reg;
          end
        end
        PAUSED:  if (start_stop) state_next = RUNNING;
        LAP: begin
          if (start_stop)  state_next = PAUSED;
          else if (lap)    state_next = RUNNING;
        end
        default: state_next = IDLE;
      endcase
      // Counting is gated by the state before this cycle's command takes effect.
      if (tick && counting) begin
        live_next = live_inc;
        wrap      = at_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      live_reg       <= 16'h0000;
      lap_reg        <= 16'h0000;
      disp_reg       <= 16'h0000;
      div_rst_reg    <= 1'b1;
      running_reg    <= 1'b0;
      lap_active_reg <= 1'b0;
      rollover_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      live_reg       <= live_next;
      lap_reg        <= lap_next;
      disp_reg       <= (state_next == LAP) ? lap_next : live_next;
      div_rst_reg    <= (state_next == IDLE) || (state_next == PAUSED);
      running_reg    <= (state_next == RUNNING) || (state_next == LAP);
      lap_active_reg <= (state_next == LAP);
      rollover_reg   <= wrap;
    end
  end

  assign state         = state_reg;
  assign div_rst       = div_rst_reg;
  assign running       = running_reg;
  assign lap_active    = lap_active_reg;
  assign rollover      = rollover_reg;
  assign disp_min_tens = disp_reg[15:12];
  assign disp_min_ones = disp_reg[11:8];
  assign disp_sec_tens = disp_reg[7:4];
  assign disp_sec_ones = disp_reg[3:0];

endmodule
